// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants for the multi-port register file: default geometry and
//   the table of registers that come out of reset with a non-zero value.
//   reset_value() turns the table into a per-index lookup usable inside
//   reset loops.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int W_DEFAULT   = 8;
  localparam int D_DEFAULT   = 3;
  localparam int NR_DEFAULT  = 3;
  localparam int NW_DEFAULT  = 2;
  localparam int TAP_DEFAULT = 6;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] value;
  } reset_entry_t;

  localparam int RESET_TABLE_LEN = 2;

  // Registers not listed here reset to zero.
  localparam reset_entry_t RESET_TABLE [RESET_TABLE_LEN] = '{
    '{idx: 32'd1, value: 32'd61},
    '{idx: 32'd5, value: 32'd140}
  };

  function automatic logic [31:0] reset_value(input logic [31:0] idx);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < RESET_TABLE_LEN; k++) begin
      if (RESET_TABLE[k].idx == idx) v = RESET_TABLE[k].value;
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
//   Bus bundle for reg_file_mp.
//   WriteEn/Waddr/DataIn : NW write ports
//   Raddr/DataOut        : NR combinational read ports
//   ResvEn/ResvAddr      : scoreboard reservation request
//   Busy                 : per-register scoreboard busy bits
//   TapOut               : fixed observation of one register
//   master = the requester driving the file, slave = the register file.
// ---------------------------------------------------------------------------
interface reg_file_mp_if
  import regfile_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int D  = D_DEFAULT,
  parameter int NR = NR_DEFAULT,
  parameter int NW = NW_DEFAULT
) ();

  logic [NW-1:0]         WriteEn;
  logic [NW-1:0][D-1:0]  Waddr;
  logic [NW-1:0][W-1:0]  DataIn;
  logic [NR-1:0][D-1:0]  Raddr;
  logic [NR-1:0][W-1:0]  DataOut;
  logic                  ResvEn;
  logic [D-1:0]          ResvAddr;
  logic [(2**D)-1:0]     Busy;
  logic [W-1:0]          TapOut;

  modport master (
    output WriteEn, Waddr, DataIn, Raddr, ResvEn, ResvAddr,
    input  DataOut, Busy, TapOut
  );

  modport slave (
    input  WriteEn, Waddr, DataIn, Raddr, ResvEn, ResvAddr,
    output DataOut, Busy, TapOut
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Owns one busy bit per register. A reservation sets the bit, any write to
//   the register clears it; reservation beats write to the same register in
//   the same cycle. Synchronous active-high reset clears all bits.
//   Ports: Clk, Reset, WriteEn/Waddr (write ports), ResvEn/ResvAddr, Busy.
//   Build option REGFILE_BYPASS_EN: Busy shows the next-state bits, so a
//   register being written this cycle already reads as not busy (unless it
//   is also being reserved). Otherwise Busy shows the stored bits only.
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int NW = NW_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NW-1:0]        WriteEn,
  input  logic [NW-1:0][D-1:0] Waddr,
  input  logic                 ResvEn,
  input  logic [D-1:0]         ResvAddr,
  output logic [(2**D)-1:0]    Busy
);

  localparam int N = 2**D;

  logic [N-1:0] write_hit;
  logic [N-1:0] resv_hit;
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  // NOTE: every signal assigned in always_comb gets a full default first so
  // no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    write_hit = '0;
    resv_hit  = '0;
    for (int j = 0; j < NW; j++) begin
      if (WriteEn[j]) write_hit[Waddr[j]] = 1'b1;
    end
    if (ResvEn) resv_hit[ResvAddr] = 1'b1;
    // Clear first, then set: a same-cycle reservation keeps the bit high.
    busy_d = (busy_q & ~write_hit) | resv_hit;
  end

  always_ff @(posedge Clk) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

`ifdef REGFILE_BYPASS_EN
  assign Busy = busy_d;
`else
  assign Busy = busy_q;
`endif

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Multi-port register file with 2**D words of W bits, NW write ports,
//   NR combinational read ports, a fixed tap on register TAP and a
//   reservation scoreboard (regfile_scoreboard) exposing per-register Busy.
//   Ports: Clk, Reset (synchronous, active-high), bus (reg_file_mp_if.slave).
//   Build option REGFILE_BYPASS_EN: reads of an address being written this
//   cycle return the winning DataIn (write-first). Without it, reads return
//   the stored value until the write lands (read-first).
// ---------------------------------------------------------------------------
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int D   = D_DEFAULT,
  parameter int NR  = NR_DEFAULT,
  parameter int NW  = NW_DEFAULT,
  parameter int TAP = TAP_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  reg_file_mp_if.slave  bus
);

  localparam int N = 2**D;

  logic [W-1:0] regs_q [N];

  // The tap behaves as one extra read port with a constant address.
  logic [D-1:0] rd_addr [NR+1];
  logic [W-1:0] rd_data [NR+1];

  // NOTE: the register contents are architectural state with defined reset
  // values, so this storage is reset explicitly rather than left as an
  // unreset memory; that keeps it in flops, which is fine at this size.
  // NOTE: non-blocking assignments in ascending port order mean the last
  // (highest-index) port writing an address is the one that sticks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int a = 0; a < N; a++) begin
        regs_q[a] <= W'(reset_value(32'(a)));
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (bus.WriteEn[j]) regs_q[bus.Waddr[j]] <= bus.DataIn[j];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd_addr
    assign rd_addr[i]     = bus.Raddr[i];
    assign bus.DataOut[i] = rd_data[i];
  end
  assign rd_addr[NR] = D'(TAP);
  assign bus.TapOut  = rd_data[NR];

  always_comb begin
    for (int i = 0; i <= NR; i++) begin
      rd_data[i] = regs_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-index matching port is forwarded,
      // matching the port that wins the write.
      for (int j = 0; j < NW; j++) begin
        if (bus.WriteEn[j] && (bus.Waddr[j] == rd_addr[i])) rd_data[i] = bus.DataIn[j];
      end
`endif
    end
  end

  regfile_scoreboard #(
    .D  (D),
    .NW (NW)
  ) u_scoreboard (
    .Clk      (Clk),
    .Reset    (Reset),
    .WriteEn  (bus.WriteEn),
    .Waddr    (bus.Waddr),
    .ResvEn   (bus.ResvEn),
    .ResvAddr (bus.ResvAddr),
    .Busy     (bus.Busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Directed bench for reg_file_mp with default parameters. Inputs change on
//   the falling edge; outputs are sampled 1 ns later, away from the rising
//   edge. Expectations covering same-cycle read/write behaviour follow the
//   REGFILE_BYPASS_EN build option.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
  import regfile_pkg::*;

  localparam int W   = 8;
  localparam int D   = 3;
  localparam int NR  = 3;
  localparam int NW  = 2;
  localparam int TAP = 6;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  reg_file_mp_if #(.W(W), .D(D), .NR(NR), .NW(NW)) bus ();

  reg_file_mp #(.W(W), .D(D), .NR(NR), .NW(NW), .TAP(TAP)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  task automatic idle();
    bus.WriteEn  = '0;
    bus.Waddr    = '0;
    bus.DataIn   = '0;
    bus.ResvEn   = 1'b0;
    bus.ResvAddr = '0;
  endtask

  task automatic drive_write(input int port, input logic [D-1:0] a, input logic [W-1:0] d);
    bus.WriteEn[port] = 1'b1;
    bus.Waddr[port]   = a;
    bus.DataIn[port]  = d;
  endtask

  task automatic drive_resv(input logic [D-1:0] a);
    bus.ResvEn   = 1'b1;
    bus.ResvAddr = a;
  endtask

  task automatic set_raddr(input logic [D-1:0] a0, input logic [D-1:0] a1, input logic [D-1:0] a2);
    bus.Raddr[0] = a0;
    bus.Raddr[1] = a1;
    bus.Raddr[2] = a2;
  endtask

  // Reset wins over a concurrent write and reservation; reset table applied.
  task automatic test_reset();
    Reset = 1'b1;
    idle();
    set_raddr(3'd0, 3'd0, 3'd0);
    @(negedge Clk);
    drive_write(0, 3'd1, 8'hAA);
    drive_resv(3'd1);
    @(negedge Clk);
    Reset = 1'b0;
    idle();
    set_raddr(3'd1, 3'd5, 3'd0);
    #1;
    checks++; if (bus.DataOut[0] !== 8'd61) begin errors++; $display("FAIL reset_reg1: got %0d expected 61", bus.DataOut[0]); end
    checks++; if (bus.DataOut[1] !== 8'd140) begin errors++; $display("FAIL reset_reg5: got %0d expected 140", bus.DataOut[1]); end
    checks++; if (bus.DataOut[2] !== 8'd0) begin errors++; $display("FAIL reset_reg0: got %0d expected 0", bus.DataOut[2]); end
    checks++; if (bus.Busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", bus.Busy); end
    checks++; if (bus.TapOut !== 8'h00) begin errors++; $display("FAIL reset_tap: got %h expected 00", bus.TapOut); end
    set_raddr(3'd2, 3'd4, 3'd7);
    #1;
    checks++; if (bus.DataOut !== 24'h0) begin errors++; $display("FAIL reset_others: got %h expected 000000", bus.DataOut); end
  endtask

  // Both ports hit reg 3 (port 1 must win), then distinct addresses.
  task automatic test_write_priority();
    @(negedge Clk);
    drive_write(0, 3'd3, 8'h11);
    drive_write(1, 3'd3, 8'h22);
    @(negedge Clk);
    idle();
    set_raddr(3'd3, 3'd0, 3'd7);
    #1;
    checks++; if (bus.DataOut[0] !== 8'h22) begin errors++; $display("FAIL prio_reg3: got %h expected 22", bus.DataOut[0]); end
    drive_write(0, 3'd0, 8'hA5);
    drive_write(1, 3'd7, 8'h3C);
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.DataOut[1] !== 8'hA5) begin errors++; $display("FAIL dual_reg0: got %h expected a5", bus.DataOut[1]); end
    checks++; if (bus.DataOut[2] !== 8'h3C) begin errors++; $display("FAIL dual_reg7: got %h expected 3c", bus.DataOut[2]); end
    checks++; if (bus.Busy !== 8'h00) begin errors++; $display("FAIL dual_busy: got %h expected 00", bus.Busy); end
  endtask

  // Reserve reg 4, then a write clears it.
  task automatic test_reserve_clear();
    @(negedge Clk);
    drive_resv(3'd4);
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.Busy !== 8'h10) begin errors++; $display("FAIL resv_set: got %h expected 10", bus.Busy); end
    drive_write(0, 3'd4, 8'h5A);
    set_raddr(3'd4, 3'd0, 3'd0);
    #1;
    checks++;
    if (bus.Busy !== (BYPASS ? 8'h00 : 8'h10)) begin
      errors++; $display("FAIL resv_busy_inflight: got %h expected %h", bus.Busy, (BYPASS ? 8'h00 : 8'h10));
    end
    checks++;
    if (bus.DataOut[0] !== (BYPASS ? 8'h5A : 8'h00)) begin
      errors++; $display("FAIL resv_read_inflight: got %h expected %h", bus.DataOut[0], (BYPASS ? 8'h5A : 8'h00));
    end
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.Busy !== 8'h00) begin errors++; $display("FAIL resv_clear: got %h expected 00", bus.Busy); end
    checks++; if (bus.DataOut[0] !== 8'h5A) begin errors++; $display("FAIL resv_data: got %h expected 5a", bus.DataOut[0]); end
  endtask

  // Reserve and write reg 2 together: reservation wins, data still lands.
  task automatic test_resv_write_same();
    @(negedge Clk);
    drive_resv(3'd2);
    drive_write(1, 3'd2, 8'h07);
    #1;
    checks++;
    if (bus.Busy !== (BYPASS ? 8'h04 : 8'h00)) begin
      errors++; $display("FAIL same_busy_inflight: got %h expected %h", bus.Busy, (BYPASS ? 8'h04 : 8'h00));
    end
    @(negedge Clk);
    idle();
    set_raddr(3'd2, 3'd0, 3'd0);
    #1;
    checks++; if (bus.Busy !== 8'h04) begin errors++; $display("FAIL same_busy: got %h expected 04", bus.Busy); end
    checks++; if (bus.DataOut[0] !== 8'h07) begin errors++; $display("FAIL same_data: got %h expected 07", bus.DataOut[0]); end
  endtask

  // No writes or reservations: everything holds.
  task automatic test_hold();
    @(negedge Clk);
    idle();
    @(negedge Clk);
    set_raddr(3'd3, 3'd2, 3'd4);
    #1;
    checks++; if (bus.DataOut[0] !== 8'h22) begin errors++; $display("FAIL hold_reg3: got %h expected 22", bus.DataOut[0]); end
    checks++; if (bus.DataOut[1] !== 8'h07) begin errors++; $display("FAIL hold_reg2: got %h expected 07", bus.DataOut[1]); end
    checks++; if (bus.DataOut[2] !== 8'h5A) begin errors++; $display("FAIL hold_reg4: got %h expected 5a", bus.DataOut[2]); end
    checks++; if (bus.Busy !== 8'h04) begin errors++; $display("FAIL hold_busy: got %h expected 04", bus.Busy); end
    checks++; if (bus.TapOut !== 8'h00) begin errors++; $display("FAIL hold_tap: got %h expected 00", bus.TapOut); end
  endtask

  // Write the tapped register while reading it.
  task automatic test_bypass();
    @(negedge Clk);
    set_raddr(3'd6, 3'd1, 3'd5);
    drive_write(0, 3'd6, 8'h99);
    #1;
    checks++;
    if (bus.DataOut[0] !== (BYPASS ? 8'h99 : 8'h00)) begin
      errors++; $display("FAIL byp_read_inflight: got %h expected %h", bus.DataOut[0], (BYPASS ? 8'h99 : 8'h00));
    end
    checks++;
    if (bus.TapOut !== (BYPASS ? 8'h99 : 8'h00)) begin
      errors++; $display("FAIL byp_tap_inflight: got %h expected %h", bus.TapOut, (BYPASS ? 8'h99 : 8'h00));
    end
    checks++; if (bus.DataOut[1] !== 8'd61) begin errors++; $display("FAIL byp_other_port: got %0d expected 61", bus.DataOut[1]); end
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.DataOut[0] !== 8'h99) begin errors++; $display("FAIL byp_read_after: got %h expected 99", bus.DataOut[0]); end
    checks++; if (bus.TapOut !== 8'h99) begin errors++; $display("FAIL byp_tap_after: got %h expected 99", bus.TapOut); end
  endtask

  // Reservations pending, then reset with a concurrent write and reserve.
  task automatic test_reset_midop();
    @(negedge Clk);
    drive_resv(3'd1);
    @(negedge Clk);
    drive_resv(3'd3);
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.Busy !== 8'h0E) begin errors++; $display("FAIL mid_busy_pre: got %h expected 0e", bus.Busy); end
    Reset = 1'b1;
    drive_write(0, 3'd1, 8'hFF);
    drive_resv(3'd3);
    @(negedge Clk);
    Reset = 1'b0;
    idle();
    set_raddr(3'd1, 3'd3, 3'd7);
    #1;
    checks++; if (bus.Busy !== 8'h00) begin errors++; $display("FAIL mid_busy_reset: got %h expected 00", bus.Busy); end
    checks++; if (bus.DataOut[0] !== 8'd61) begin errors++; $display("FAIL mid_reg1: got %0d expected 61", bus.DataOut[0]); end
    checks++; if (bus.DataOut[1] !== 8'h00) begin errors++; $display("FAIL mid_reg3: got %h expected 00", bus.DataOut[1]); end
    checks++; if (bus.DataOut[2] !== 8'h00) begin errors++; $display("FAIL mid_reg7: got %h expected 00", bus.DataOut[2]); end
    checks++; if (bus.TapOut !== 8'h00) begin errors++; $display("FAIL mid_tap: got %h expected 00", bus.TapOut); end
    drive_write(1, 3'd1, 8'h42);
    drive_resv(3'd5);
    @(negedge Clk);
    idle();
    #1;
    checks++; if (bus.DataOut[0] !== 8'h42) begin errors++; $display("FAIL post_reset_write: got %h expected 42", bus.DataOut[0]); end
    checks++; if (bus.Busy !== 8'h20) begin errors++; $display("FAIL post_reset_resv: got %h expected 20", bus.Busy); end
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_reserve_clear();
    test_resv_write_same();
    test_hold();
    test_bypass();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
